seg_scan: RTL

- Parametrised time-multiplexed driver for a DIGITS-wide common-bus 7-segment display.
- Next generation of the chess-clock single-glyph segment driver: per-digit glyph codes, decimal points, per-digit blink and one-hot digit scanning.
- Sits between the clock/timer core, which supplies glyph codes per digit, and the board display pins.
- Inputs are frame-latched, so a digit never changes mid-frame (no tearing).

---
 rtl/seg_scan_if.sv | 23 ++
 rtl/seg_scan.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Signal bundle between the timer core (master) and the display scanner (slave).
// No handshake: master holds en/glyph/dp/blink as levels; slave drives seg/an every cycle, frame_done pulses once per frame.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [5*DIGITS-1:0]   glyph;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blink;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output en, glyph, dp, blink,
    input  seg, an, frame_done
  );

  modport slave (
    input  en, glyph, dp, blink,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed multi-digit 7-segment driver with frame-latched glyphs,
// decimal points and per-digit blink.
module seg_scan #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [PW-1:0]            presc_q, presc_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [FW-1:0]            frame_q, frame_d;
  logic                     blink_phase_q, blink_phase_d;
  logic                     load_pending_q, load_pending_d;
  logic [DIGITS-1:0][4:0]   sh_glyph_q, sh_glyph_d;
  logic [DIGITS-1:0]        sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]        sh_blink_q, sh_blink_d;
  logic [7:0]               seg_q, seg_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic                     frame_done_q, frame_done_d;

  logic presc_term, idx_term, wrap, frame_term, load;
  logic [4:0] cur_glyph;

  function automatic logic [6:0] font(input logic [4:0] code);
    case (code)
      5'd0:    font = 7'h3F;
      5'd1:    font = 7'h06;
      5'd2:    font = 7'h5B;
      5'd3:    font = 7'h4F;
      5'd4:    font = 7'h66;
      5'd5:    font = 7'h6D;
      5'd6:    font = 7'h7D;
      5'd7:    font = 7'h07;
      5'd8:    font = 7'h7F;
      5'd9:    font = 7'h6F;
      5'd10:   font = 7'h77;
      5'd11:   font = 7'h7C;
      5'd12:   font = 7'h39;
      5'd13:   font = 7'h5E;
      5'd14:   font = 7'h79;
      5'd15:   font = 7'h71;
      5'd16:   font = 7'h40;
      5'd17:   font = 7'h73;
      default: font = 7'h00;
    endcase
  endfunction

  always_comb begin
    presc_term     = (presc_q == PW'(SCAN_DIV - 1));
    idx_term       = (idx_q == IW'(DIGITS - 1));
    wrap           = presc_term && idx_term;
    frame_term     = (frame_q == FW'(BLINK_FRAMES - 1));
    // The first edge after reset also loads, so frame 0 shows real data.
    load           = wrap || load_pending_q;
    cur_glyph      = sh_glyph_q[idx_q];

    presc_d        = presc_term ? '0 : presc_q + PW'(1);
    idx_d          = idx_q;
    if (presc_term) idx_d = idx_term ? '0 : idx_q + IW'(1);

    frame_d        = frame_q;
    blink_phase_d  = blink_phase_q;
    if (wrap) begin
      frame_d       = frame_term ? '0 : frame_q + FW'(1);
      blink_phase_d = frame_term ? ~blink_phase_q : blink_phase_q;
    end

    sh_glyph_d     = sh_glyph_q;
    sh_dp_d        = sh_dp_q;
    sh_blink_d     = sh_blink_q;
    load_pending_d = load_pending_q;
    if (load) begin
      sh_glyph_d     = bus.glyph;
      sh_dp_d        = bus.dp;
      sh_blink_d     = bus.blink;
      load_pending_d = 1'b0;
    end

    seg_d = 8'h00;
    an_d  = '0;
    if (bus.en) begin
      an_d = DIGITS'(1) << idx_q;
      if (!(blink_phase_q && sh_blink_q[idx_q])) seg_d = {sh_dp_q[idx_q], font(cur_glyph)};
    end

    frame_done_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q        <= '0;
      idx_q          <= '0;
      frame_q        <= '0;
      blink_phase_q  <= 1'b0;
      load_pending_q <= 1'b1;
      sh_glyph_q     <= {DIGITS{5'd31}};
      sh_dp_q        <= '0;
      sh_blink_q     <= '0;
      seg_q          <= 8'h00;
      an_q           <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      frame_q        <= frame_d;
      blink_phase_q  <= blink_phase_d;
      load_pending_q <= load_pending_d;
      sh_glyph_q     <= sh_glyph_d;
      sh_dp_q        <= sh_dp_d;
      sh_blink_q     <= sh_blink_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
endmodule
